// File: rtl/axil_fifo_bridge_pkg.sv
// Shared constants and types for the AXI-Lite <-> streaming FIFO bridge.
// Optional loopback register is enabled by defining AXIL_FIFO_BRIDGE_LOOPBACK_EN.
package axil_fifo_bridge_pkg;

    localparam logic [11:0] OFF_TX_DATA  = 12'h000;
    localparam logic [11:0] OFF_TX_VAC   = 12'h004;
    localparam logic [11:0] OFF_RX_DATA  = 12'h008;
    localparam logic [11:0] OFF_RX_OCC   = 12'h00C;
    localparam logic [11:0] OFF_STATUS   = 12'h010;
`ifdef AXIL_FIFO_BRIDGE_LOOPBACK_EN
    localparam logic [11:0] OFF_LOOPBACK = 12'h014;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_RX_EMPTY = 1;
    localparam int ST_TX_OVF   = 2;
    localparam int ST_RX_UDF   = 3;

    typedef struct packed {
        logic rx_udf;
        logic tx_ovf;
        logic rx_empty;
        logic tx_full;
    } status_t;

endpackage

// File: rtl/axil_fifo_bridge_fifo.sv
// Synchronous single-clock FIFO with occupancy count; push/pop must be pre-qualified by the caller.
// Head reads as zero while empty so the exposed data port is clean out of reset.
module axil_fifo_bridge_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rptr];

endmodule

// File: rtl/axil_fifo_bridge.sv
// AXI-Lite slave bridging MMIO to a TX and an RX stream FIFO, one outstanding read and write.
// Define AXIL_FIFO_BRIDGE_LOOPBACK_EN to add the internal TX->RX loopback register at 0x014.
module axil_fifo_bridge
    import axil_fifo_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [31:0]           tx_data_o,
    output logic                  tx_v_o,
    input  logic                  tx_ready_i,
    input  logic [31:0]           rx_data_i,
    input  logic                  rx_v_i,
    output logic                  rx_ready_o
);

    localparam int TCW = $clog2(TX_DEPTH + 1);
    localparam int RCW = $clog2(RX_DEPTH + 1);

    logic        aw_held, w_held, w_any;
    logic [11:0] aw_off, ar_off;
    logic [31:0] w_data, rd_word;
    logic        tx_ovf, rx_udf;
    status_t     status;

    logic [31:0]    tx_head, rx_head, rx_in;
    logic [TCW-1:0] tx_count;
    logic [RCW-1:0] rx_count;
    logic           tx_full, tx_empty, rx_full, rx_empty;
    logic           tx_push, tx_pop, rx_push, rx_pop;

    logic aw_fire, w_fire, ar_fire, wr_do;
    logic wr_tx, wr_sts, rd_rx, tx_ovf_set, rx_udf_set;

    assign s_awready = ~aw_held & ~s_bvalid;
    assign s_wready  = ~w_held & ~s_bvalid;
    assign s_arready = ~s_rvalid;

    assign aw_fire = s_awvalid & s_awready;
    assign w_fire  = s_wvalid & s_wready;
    assign ar_fire = s_arvalid & s_arready;
    assign wr_do   = aw_held & w_held;
    assign ar_off  = 12'(s_araddr);

    // An all-zero strobe turns any write into an OKAY no-op.
    assign wr_tx  = wr_do & w_any & (aw_off == OFF_TX_DATA);
    assign wr_sts = wr_do & w_any & (aw_off == OFF_STATUS);
    assign rd_rx  = ar_fire & (ar_off == OFF_RX_DATA);

    // A same-cycle fabric pop frees the slot, so a push into a full TX is still accepted.
    assign tx_push    = wr_tx & (~tx_full | tx_pop);
    assign tx_ovf_set = wr_tx & tx_full & ~tx_pop;
    assign rx_pop     = rd_rx & ~rx_empty;
    assign rx_udf_set = rd_rx & rx_empty;

`ifdef AXIL_FIFO_BRIDGE_LOOPBACK_EN
    logic lb, lb_xfer;
    assign lb_xfer    = lb & ~tx_empty & ~rx_full;
    assign tx_pop     = lb ? lb_xfer : (tx_ready_i & ~tx_empty);
    assign rx_push    = lb ? lb_xfer : (rx_v_i & ~rx_full);
    assign rx_in      = lb ? tx_head : rx_data_i;
    assign tx_v_o     = ~tx_empty & ~lb;
    assign rx_ready_o = ~rx_full & ~lb;
`else
    assign tx_pop     = tx_ready_i & ~tx_empty;
    assign rx_push    = rx_v_i & ~rx_full;
    assign rx_in      = rx_data_i;
    assign tx_v_o     = ~tx_empty;
    assign rx_ready_o = ~rx_full;
`endif
    assign tx_data_o = tx_head;

    assign status = '{rx_udf: rx_udf, tx_ovf: tx_ovf, rx_empty: rx_empty, tx_full: tx_full};

    always_comb begin
        rd_word = '0;
        case (ar_off)
            OFF_TX_VAC:   rd_word = 32'(TX_DEPTH) - 32'(tx_count);
            OFF_RX_DATA:  rd_word = rx_head;
            OFF_RX_OCC:   rd_word = 32'(rx_count);
            OFF_STATUS:   rd_word = 32'(status);
`ifdef AXIL_FIFO_BRIDGE_LOOPBACK_EN
            OFF_LOOPBACK: rd_word = 32'(lb);
`endif
            default:      rd_word = '0;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_held  <= 1'b0;
            aw_off   <= '0;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_any    <= 1'b0;
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
            tx_ovf   <= 1'b0;
            rx_udf   <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_off  <= 12'(s_awaddr);
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= s_wdata;
                w_any  <= |s_wstrb;
            end
            if (wr_do) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= tx_ovf_set ? RESP_SLVERR : RESP_OKAY;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end
            if (ar_fire) begin
                s_rvalid <= 1'b1;
                s_rdata  <= rd_word;
                s_rresp  <= rx_udf_set ? RESP_SLVERR : RESP_OKAY;
            end else if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
            end
            // New error events win over a same-cycle write-1-to-clear.
            tx_ovf <= tx_ovf_set | (tx_ovf & ~(wr_sts & w_data[ST_TX_OVF]));
            rx_udf <= rx_udf_set | (rx_udf & ~(wr_sts & w_data[ST_RX_UDF]));
        end
    end

`ifdef AXIL_FIFO_BRIDGE_LOOPBACK_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            lb <= 1'b0;
        else if (wr_do && w_any && aw_off == OFF_LOOPBACK)
            lb <= w_data[0];
    end
`endif

    axil_fifo_bridge_fifo #(.DEPTH(TX_DEPTH), .WIDTH(32)) u_tx (
        .clk(aclk), .rst(areset), .push(tx_push), .push_data(w_data), .pop(tx_pop),
        .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    axil_fifo_bridge_fifo #(.DEPTH(RX_DEPTH), .WIDTH(32)) u_rx (
        .clk(aclk), .rst(areset), .push(rx_push), .push_data(rx_in), .pop(rx_pop),
        .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

endmodule

// File: tb/tb_axil_fifo_bridge.sv
// Bench for axil_fifo_bridge: queue-based bus model checked every cycle plus directed literal checks.
// Covers the AXIL_FIFO_BRIDGE_LOOPBACK_EN build as well when that macro is defined.
module tb_axil_fifo_bridge;

    localparam int TXD = 16;
    localparam int RXD = 16;
`ifdef AXIL_FIFO_BRIDGE_LOOPBACK_EN
    localparam bit LB_EN = 1'b1;
`else
    localparam bit LB_EN = 1'b0;
`endif

    logic        aclk = 1'b0, areset = 1'b0;
    logic [11:0] s_awaddr = '0, s_araddr = '0;
    logic        s_awvalid = 0, s_wvalid = 0, s_bready = 1, s_arvalid = 0, s_rready = 1;
    logic [31:0] s_wdata = '0, rx_data_i = '0;
    logic [3:0]  s_wstrb = '0;
    logic        tx_ready_i = 0, rx_v_i = 0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, tx_v_o, rx_ready_o;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata, tx_data_o;

    axil_fifo_bridge dut (
        .aclk(aclk), .areset(areset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .tx_data_o(tx_data_o), .tx_v_o(tx_v_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_v_i(rx_v_i), .rx_ready_o(rx_ready_o)
    );

    initial forever #5 aclk = ~aclk;

    int n_cmp = 0, n_err = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void timeout(string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired", nm);
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] txq[$], rxq[$];
    bit          m_aw_held = 0, m_w_held = 0, m_bvalid = 0, m_rvalid = 0;
    bit          m_ovf = 0, m_udf = 0, m_lb = 0;
    logic [11:0] m_aw_off = '0;
    logic [31:0] m_w_data = '0, m_rdata = '0;
    logic [3:0]  m_w_strb = '0;
    logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            txq.delete(); rxq.delete();
            m_aw_held = 0; m_w_held = 0; m_bvalid = 0; m_rvalid = 0;
            m_ovf = 0; m_udf = 0; m_lb = 0;
            m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
        end else begin
            int txn, rxn;
            bit tx_pop, lbx, rx_push, aw_f, w_f, ar_f, tx_push, rd_pop;
            bit ovf_set, udf_set, ovf_clr, udf_clr;
            logic [31:0] lb_word;
            txn = txq.size(); rxn = rxq.size();
            tx_pop  = !m_lb && txn > 0 && tx_ready_i;
            lbx     = m_lb && txn > 0 && rxn < RXD;
            rx_push = !m_lb && rx_v_i && rxn < RXD;
            aw_f = s_awvalid && !m_aw_held && !m_bvalid;
            w_f  = s_wvalid && !m_w_held && !m_bvalid;
            ar_f = s_arvalid && !m_rvalid;
            tx_push = 0; rd_pop = 0; ovf_set = 0; udf_set = 0; ovf_clr = 0; udf_clr = 0;
            lb_word = '0;
            if (m_bvalid && s_bready) m_bvalid = 0;
            if (m_rvalid && s_rready) m_rvalid = 0;
            if (ar_f) begin
                m_rvalid = 1; m_rresp = 2'b00; m_rdata = '0;
                case (s_araddr)
                    12'h004: m_rdata = TXD - txn;
                    12'h008: if (rxn == 0) begin m_rresp = 2'b10; udf_set = 1; end
                             else begin m_rdata = rxq[0]; rd_pop = 1; end
                    12'h00C: m_rdata = rxn;
                    12'h010: m_rdata = {28'd0, m_udf, m_ovf, rxn == 0, txn == TXD};
                    12'h014: m_rdata = LB_EN ? 32'(m_lb) : 32'd0;
                    default: m_rdata = '0;
                endcase
            end
            if (m_aw_held && m_w_held) begin
                m_bvalid = 1; m_bresp = 2'b00; m_aw_held = 0; m_w_held = 0;
                if (m_w_strb != 0) begin
                    case (m_aw_off)
                        12'h000: if (txn == TXD && !tx_pop) begin m_bresp = 2'b10; ovf_set = 1; end
                                 else tx_push = 1;
                        12'h010: begin ovf_clr = m_w_data[2]; udf_clr = m_w_data[3]; end
                        12'h014: if (LB_EN) m_lb = m_w_data[0];
                        default: ;
                    endcase
                end
            end
            if (aw_f) begin m_aw_held = 1; m_aw_off = s_awaddr; end
            if (w_f)  begin m_w_held = 1; m_w_data = s_wdata; m_w_strb = s_wstrb; end
            if (tx_pop || lbx) lb_word = txq.pop_front();
            if (tx_push) txq.push_back(m_w_data);
            if (rd_pop) void'(rxq.pop_front());
            if (rx_push) rxq.push_back(rx_data_i);
            if (lbx) rxq.push_back(lb_word);
            m_ovf = (m_ovf && !ovf_clr) || ovf_set;
            m_udf = (m_udf && !udf_clr) || udf_set;
        end
    end

    always @(negedge aclk) begin
        chk("awready", s_awready, !m_aw_held && !m_bvalid);
        chk("wready", s_wready, !m_w_held && !m_bvalid);
        chk("arready", s_arready, !m_rvalid);
        chk("bvalid", s_bvalid, m_bvalid);
        if (m_bvalid) chk("bresp", s_bresp, m_bresp);
        chk("rvalid", s_rvalid, m_rvalid);
        if (m_rvalid) begin
            chk("rdata", s_rdata, m_rdata);
            chk("rresp", s_rresp, m_rresp);
        end
        chk("tx_v", tx_v_o, txq.size() > 0 && !m_lb);
        if (txq.size() > 0) chk("tx_data", tx_data_o, txq[0]);
        chk("rx_ready", rx_ready_o, rxq.size() < RXD && !m_lb);
    end

    // ---------------- host / fabric tasks ----------------
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st,
                             input int wdly, output logic [1:0] resp, output int lat);
        bit aw_done = 0, w_done = 0;
        int n = 0;
        s_awaddr = a; s_awvalid = 1; s_wdata = d; s_wstrb = st; s_wvalid = (wdly == 0);
        while (!(aw_done && w_done) && n < 50) begin
            @(posedge aclk);
            if (s_awvalid && s_awready) aw_done = 1;
            if (s_wvalid && s_wready) w_done = 1;
            #1; n++;
            if (aw_done) s_awvalid = 0;
            if (w_done) s_wvalid = 0; else if (n >= wdly) s_wvalid = 1;
        end
        s_awvalid = 0; s_wvalid = 0;
        if (!(aw_done && w_done)) timeout("write_accept");
        n = 0;
        while (!s_bvalid && n < 50) begin @(posedge aclk); #1; n++; end
        if (!s_bvalid) timeout("bvalid_wait");
        resp = s_bresp; lat = n;
        @(posedge aclk); #1;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        bit fired = 0;
        s_araddr = a; s_arvalid = 1;
        while (!fired && n < 50) begin
            @(posedge aclk); fired = s_arready; #1; n++;
        end
        s_arvalid = 0;
        if (!fired) timeout("ar_accept");
        n = 0;
        while (!s_rvalid && n < 50) begin @(posedge aclk); #1; n++; end
        if (!s_rvalid) timeout("rvalid_wait");
        d = s_rdata; resp = s_rresp;
        @(posedge aclk); #1;
    endtask

    task automatic rx_send(input logic [31:0] w);
        int n = 0;
        bit fired = 0;
        rx_data_i = w; rx_v_i = 1;
        while (!fired && n < 300) begin
            @(posedge aclk); fired = rx_ready_o; #1; n++;
        end
        rx_v_i = 0;
        if (!fired) timeout("rx_send");
    endtask

    task automatic tx_drain();
        int n = 0;
        tx_ready_i = 1;
        while (tx_v_o && n < 50) begin @(posedge aclk); #1; n++; end
        tx_ready_i = 0;
        if (tx_v_o) timeout("tx_drain");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        bit          bf, rf;
        #1 areset = 1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_awready", s_awready, 1); chk("rst_wready", s_wready, 1);
        chk("rst_arready", s_arready, 1); chk("rst_rx_ready", rx_ready_o, 1);
        chk("rst_bvalid", s_bvalid, 0);   chk("rst_rvalid", s_rvalid, 0);
        chk("rst_tx_v", tx_v_o, 0);       chk("rst_tx_data", tx_data_o, 0);
        chk("rst_rdata", s_rdata, 0);     chk("rst_bresp", s_bresp, 0);
        @(posedge aclk); #1 areset = 0;

        // Reset lands while a write is held: no B may follow.
        s_awaddr = 12'h000; s_wdata = 32'h11; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
        @(posedge aclk); #1 s_awvalid = 0; s_wvalid = 0; areset = 1;
        @(posedge aclk); #1 areset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("midrst_bvalid", s_bvalid, 0);
            chk("midrst_tx_v", tx_v_o, 0);
        end
        @(posedge aclk); #1;

        // First write, AW two cycles ahead of W.
        axi_write(12'h000, 32'hDEADBEEF, 4'hF, 2, r, lat);
        chk("w1_bresp", r, 2'b00);
        chk("w1_b_latency", lat, 1);
        @(negedge aclk);
        chk("w1_tx_v", tx_v_o, 1);
        chk("w1_tx_data", tx_data_o, 32'hDEADBEEF);
        #1;
        axi_read(12'h004, d, r);
        chk("tx_vac_15", d, 15);
        axi_write(12'h000, 32'h0BAD0BAD, 4'h0, 0, r, lat);
        chk("zero_strb_bresp", r, 2'b00);
        axi_read(12'h004, d, r);
        chk("zero_strb_vac", d, 15);
        tx_drain();

        // Overflow: 17 pushes with the fabric stalled.
        rx_send(32'h77);
        for (int i = 0; i < 17; i++) begin
            axi_write(12'h000, 32'h1000 + i, 4'hF, 0, r, lat);
            chk($sformatf("ovf_push%0d", i), r, (i == 16) ? 2'b10 : 2'b00);
        end
        axi_read(12'h010, d, r);
        chk("status_after_ovf", d, 32'h5);
        axi_write(12'h010, 32'h4, 4'hF, 0, r, lat);
        axi_read(12'h010, d, r);
        chk("status_after_clr", d, 32'h1);
        axi_read(12'h004, d, r);
        chk("tx_vac_full", d, 0);
        tx_drain();

        // RX ordering and underflow.
        axi_read(12'h008, d, r);
        chk("rx_pre_word", d, 32'h77);
        rx_send(32'h1); rx_send(32'h2); rx_send(32'h3);
        axi_read(12'h00C, d, r);
        chk("rx_occ_3", d, 3);
        for (int i = 1; i <= 3; i++) begin
            axi_read(12'h008, d, r);
            chk($sformatf("rx_word%0d", i), d, i);
        end
        axi_read(12'h008, d, r);
        chk("udf_rdata", d, 0);
        chk("udf_rresp", r, 2'b10);
        axi_read(12'h010, d, r);
        chk("status_udf", d, 32'hA);
        axi_write(12'h010, 32'h8, 4'hF, 0, r, lat);
        axi_read(12'h010, d, r);
        chk("status_udf_clr", d, 32'h2);

        // RX full with the fabric streaming while the host pops.
        fork
            begin
                for (int k = 0; k < 100; k++) begin
                    rx_send(32'h200 + k);
                    if ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
                end
            end
            begin
                int got = 0, tries = 0, n = 0;
                while (rx_ready_o && n < 200) begin @(posedge aclk); #1; n++; end
                chk("rx_full_ready", rx_ready_o, 0);
                s_araddr = 12'h008; s_arvalid = 1;
                @(posedge aclk); #1 s_arvalid = 0;
                chk("rx_ready_after_pop", rx_ready_o, 1);
                @(posedge aclk); #1;
                chk("stream_first", s_rdata, 32'h200);
                got = 1;
                while (got < 100 && tries < 600) begin
                    axi_read(12'h008, d, r);
                    tries++;
                    if (r == 2'b00) begin
                        chk("stream_word", d, 32'h200 + got);
                        got++;
                    end
                    repeat ($urandom_range(0, 2)) @(posedge aclk);
                    #1;
                end
                chk("stream_count", got, 100);
            end
        join
        axi_write(12'h010, 32'h8, 4'hF, 0, r, lat);

        // Backpressure on B and R.
        rx_send(32'h5);
        s_bready = 0; s_rready = 0;
        s_awaddr = 12'h100; s_wdata = 32'h99; s_wstrb = 4'hF; s_araddr = 12'h00C;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        @(posedge aclk); #1 s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        bf = 0; rf = 0;
        for (int i = 0; i < 10 && !(bf && rf); i++) begin
            @(posedge aclk); #1; bf = s_bvalid; rf = s_rvalid;
        end
        if (!(bf && rf)) timeout("bp_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("bp_bvalid", s_bvalid, 1); chk("bp_bresp", s_bresp, 2'b00);
            chk("bp_rvalid", s_rvalid, 1); chk("bp_rdata", s_rdata, 1);
            chk("bp_awready", s_awready, 0); chk("bp_wready", s_wready, 0);
            chk("bp_arready", s_arready, 0);
        end
        @(posedge aclk); #1 s_bready = 1; s_rready = 1;
        @(posedge aclk); @(negedge aclk);
        chk("bp_release_b", s_bvalid, 0);
        chk("bp_release_r", s_rvalid, 0);
        #1;
        axi_read(12'h008, d, r);
        chk("bp_drain", d, 32'h5);

        // Loopback register (unmapped in the default build).
        axi_write(12'h014, 32'h1, 4'hF, 0, r, lat);
        chk("lb_wr_bresp", r, 2'b00);
        axi_read(12'h014, d, r);
        chk("lb_readback", d, LB_EN ? 32'h1 : 32'h0);
        if (LB_EN) begin
            axi_write(12'h000, 32'hA5, 4'hF, 0, r, lat);
            @(negedge aclk);
            chk("lb_tx_v", tx_v_o, 0);
            #1;
            axi_read(12'h00C, d, r);
            chk("lb_rx_occ", d, 1);
            axi_read(12'h008, d, r);
            chk("lb_rx_data", d, 32'hA5);
            axi_write(12'h014, 32'h0, 4'hF, 0, r, lat);
        end

        repeat (3) @(posedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
